// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers, field positions, ExcCodes and register pack helpers.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int CA_IP_LO = 8;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BP  = 5'd9,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_e;

    function automatic logic [31:0] pack_status(input logic ie, input logic exl, input logic [7:0] im);
        return {16'b0, im, 6'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [7:0] ip, input logic [4:0] code);
        return {bd, 15'b0, ip, 1'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with prescaler and sticky timer interrupt TI.
//  clk, rst (async, active-high)
//  count_we / compare_we : mtc0 writes (already qualified by the exception/eret priority)
//  wdata                 : mtc0 data
//  count, compare, ti    : register state
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = pre == PRE_MAX;
    assign count_inc = count + 32'd1;

    // Match is checked against the post-increment value; any timer write in the same cycle wins over it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            pre     <= (count_we | tick) ? '0 : pre + 1'b1;
            count   <= count_we ? wdata : tick ? count_inc : count;
            compare <= compare_we ? wdata : compare;
            ti      <= compare_we ? 1'b0 : (!count_we && tick && count_inc == compare) ? 1'b1 : ti;
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: Minisys-1A CP0 with Status/Cause/EPC, masked interrupt request, EXL nesting, ERET and optional timer.
//  clk, rst (async, active-high)
//  we/waddr/wdata : mtc0 write      raddr/rdata : mfc0 read (combinational, no bypass)
//  ext_int        : level interrupt lines, sampled into Cause.IP[2 +: NUM_EXT_INT]
//  exc_req/exc_code/exc_pc/exc_bd : exception entry   eret : exception return
//  int_req        : unmasked pending interrupt         epc_o : EPC to the PC mux
//  Define CP0_TIMER_EN to build the Count/Compare timer (cp0_timer); otherwise regs 9/11 read 0.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_EXT_INT  = 6,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0001,
    parameter int          COUNT_DIV    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [4:0]             waddr,
    input  logic [31:0]            wdata,
    input  logic [4:0]             raddr,
    output logic [31:0]            rdata,
    input  logic [NUM_EXT_INT-1:0] ext_int,
    input  logic                   exc_req,
    input  logic [4:0]             exc_code,
    input  logic [31:0]            exc_pc,
    input  logic                   exc_bd,
    input  logic                   eret,
    output logic                   int_req,
    output logic [31:0]            epc_o
);

    logic                   ie, exl, bd;
    logic [7:0]             im;
    logic [1:0]             ip_sw;
    logic [4:0]             code_q;
    logic [31:0]            epc;
    logic [NUM_EXT_INT-1:0] ext_q;
    logic [5:0]             ip_hw;
    logic [7:0]             ip;
    logic                   mtc0;
    logic                   ti;
    logic [31:0]            count, compare;

    // mtc0 only lands when neither an exception nor an eret claims the cycle.
    assign mtc0 = we & ~exc_req & ~eret;

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0 && waddr == CP0_COUNT),
        .compare_we (mtc0 && waddr == CP0_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    logic unused_cfg;
    assign unused_cfg = COUNT_DIV[0];
    assign ti         = 1'b0;
    assign count      = '0;
    assign compare    = '0;
`endif

    assign ip_hw   = 6'(ext_q);
    assign ip      = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign int_req = ie & ~exl & |(ip & im);
    assign epc_o   = epc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie     <= RESET_STATUS[ST_IE];
            exl    <= RESET_STATUS[ST_EXL];
            im     <= RESET_STATUS[ST_IM_LO +: 8];
            bd     <= 1'b0;
            ip_sw  <= '0;
            code_q <= '0;
            epc    <= '0;
            ext_q  <= '0;
        end else begin
            ext_q <= ext_int;
            if (exc_req) begin
                code_q <= exc_code;
                exl    <= 1'b1;
                // A nested exception keeps the outer restart point.
                if (!exl) begin
                    epc <= exc_pc;
                    bd  <= exc_bd;
                end
            end else if (eret) begin
                exl <= 1'b0;
            end else if (mtc0) begin
                case (waddr)
                    CP0_STATUS: begin
                        ie  <= wdata[ST_IE];
                        exl <= wdata[ST_EXL];
                        im  <= wdata[ST_IM_LO +: 8];
                    end
                    CP0_CAUSE: ip_sw <= wdata[CA_IP_LO +: 2];
                    CP0_EPC:   epc   <= wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            CP0_STATUS:  rdata = pack_status(ie, exl, im);
            CP0_CAUSE:   rdata = pack_cause(bd, ip, code_q);
            CP0_EPC:     rdata = epc;
            default:     rdata = '0;
        endcase
    end

endmodule
